// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns the SPI bridge byte stream into register-file reads and writes.
// Latency: reg_we/reg_re 1 clk after byte_sync; read data appears on data_out 2 clks after the command byte.
// Backpressure: none; the bridge paces bytes and a stalled transaction is aborted after TIMEOUT_CYC clks.
module spi_cmd_decoder #(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err_timeout
);

    // Wide enough to hold TIMEOUT_CYC-1, the terminal count.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_WDATA = 2'd1,
        S_RWAIT = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;

    // A transaction is abandoned only when the terminal count is reached with no byte
    // arriving that same cycle; a coincident byte is processed instead.
    assign timeout_hit = (state != S_CMD) && !byte_sync && (idle_cnt == TERM_CNT);

    // Inactivity counter: only runs while a transaction is open and no byte arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == S_CMD || byte_sync || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Transaction FSM with registered strobes, data and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CMD;
            data_out    <= 8'h00;
            reg_addr    <= '0;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            err_timeout <= 1'b0;
            if (timeout_hit) begin
                // Abort: no strobe, address left as it was, MISO back to idle.
                state       <= S_CMD;
                data_out    <= 8'h00;
                busy        <= 1'b0;
                err_timeout <= 1'b1;
            end else begin
                case (state)
                    S_CMD: begin
                        if (byte_sync) begin
                            reg_addr <= data_in[ADDR_W-1:0];
                            busy     <= 1'b1;
                            if (data_in[7]) begin
                                state <= S_WDATA;
                            end else begin
                                reg_re <= 1'b1;
                                state  <= S_RWAIT;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (byte_sync) begin
                            reg_wdata <= data_in;
                            reg_we    <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_CMD;
                        end
                    end
                    S_RWAIT: begin
                        // The register file answers reg_addr during the reg_re cycle;
                        // capture it at the end of that cycle. Bytes here cannot occur
                        // at the guaranteed byte period and are ignored.
                        data_out <= reg_rdata;
                        state    <= S_RDATA;
                    end
                    S_RDATA: begin
                        // Dummy byte shifted out the read value; its content is ignored.
                        if (byte_sync) begin
                            data_out <= 8'h00;
                            busy     <= 1'b0;
                            state    <= S_CMD;
                        end
                    end
                    default: begin
                        state <= S_CMD;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: a transaction-level model schedules the expected
// output timeline per cycle and one process compares the DUT against it every cycle.
module tb_spi_cmd_decoder;

    localparam int ADDR_W  = 6;
    localparam int TMO     = 64;
    localparam int MAXC    = 4096;
    localparam int NREG    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              byte_sync = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              err_timeout;

    spi_cmd_decoder #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .byte_sync(byte_sync), .data_in(data_in),
        .data_out(data_out), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file stub: combinational read of reg_addr, written on reg_we.
    logic [7:0] stub_mem [NREG];
    assign reg_rdata = stub_mem[reg_addr];
    always @(posedge clk) if (reg_we) stub_mem[reg_addr] <= reg_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- expected timeline ----------------
    bit         e_we  [MAXC];
    bit         e_re  [MAXC];
    bit         e_err [MAXC];
    bit         b_set [MAXC];
    bit         b_val [MAXC];
    bit         a_set [MAXC];
    logic [7:0] a_val [MAXC];
    bit         d_set [MAXC];
    logic [7:0] d_val [MAXC];
    bit         w_set [MAXC];
    logic [7:0] w_val [MAXC];

    logic [7:0] model_mem [NREG];
    int         m_open = 0;      // 0 idle, 1 write pending, 2 read pending
    int         m_addr = 0;
    int         m_dead = 0;      // last cycle a byte can still rescue the transaction

    task automatic put_busy(input int c, input bit v);
        if (c < MAXC) begin b_set[c] = 1; b_val[c] = v; end
    endtask
    task automatic put_dout(input int c, input logic [7:0] v);
        if (c < MAXC) begin d_set[c] = 1; d_val[c] = v; end
    endtask

    task automatic m_cancel_timeout();
        if (m_dead + 1 < MAXC) begin
            e_err[m_dead+1] = 0; b_set[m_dead+1] = 0; d_set[m_dead+1] = 0;
        end
    endtask

    task automatic model_reset(input int r);
        for (int i = r + 1; i < MAXC; i++) begin
            e_we[i] = 0; e_re[i] = 0; e_err[i] = 0;
            b_set[i] = 0; a_set[i] = 0; d_set[i] = 0; w_set[i] = 0;
        end
        put_busy(r + 1, 0);
        put_dout(r + 1, 8'h00);
        a_set[r+1] = 1; a_val[r+1] = 8'h00;
        w_set[r+1] = 1; w_val[r+1] = 8'h00;
        m_open = 0;
    endtask

    // A byte presented during cycle c; its effects are seen from cycle c+1.
    task automatic model_byte(input int c, input logic [7:0] b);
        if (m_open != 0 && c > m_dead) m_open = 0;   // already timed out
        if (m_open == 0) begin
            m_addr = int'(b) % NREG;
            a_set[c+1] = 1; a_val[c+1] = 8'(m_addr);
            put_busy(c + 1, 1);
            m_dead = c + TMO;
            if (b[7]) begin
                m_open = 1;
            end else begin
                m_open = 2;
                e_re[c+1] = 1;
                put_dout(c + 2, model_mem[m_addr]);
            end
            if (m_dead + 1 < MAXC) e_err[m_dead+1] = 1;
            put_busy(m_dead + 1, 0);
            put_dout(m_dead + 1, 8'h00);
        end else if (m_open == 1) begin
            m_cancel_timeout();
            e_we[c+1] = 1;
            w_set[c+1] = 1; w_val[c+1] = b;
            put_busy(c + 1, 0);
            model_mem[m_addr] = b;
            m_open = 0;
        end else begin
            m_cancel_timeout();
            put_dout(c + 1, 8'h00);
            put_busy(c + 1, 0);
            m_open = 0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit         cmp_en = 0;
    bit         x_busy;
    logic [7:0] x_addr, x_dout, x_wdata;
    int         we_cnt = 0, re_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (reg_we === 1'b1) we_cnt++;
        if (reg_re === 1'b1) re_cnt++;
        if (err_timeout === 1'b1) err_cnt++;
        if (cmp_en && cyc < MAXC) begin
            if (b_set[cyc]) x_busy  = b_val[cyc];
            if (a_set[cyc]) x_addr  = a_val[cyc];
            if (d_set[cyc]) x_dout  = d_val[cyc];
            if (w_set[cyc]) x_wdata = w_val[cyc];
            chk("reg_we",      reg_we,      e_we[cyc]);
            chk("reg_re",      reg_re,      e_re[cyc]);
            chk("err_timeout", err_timeout, e_err[cyc]);
            chk("busy",        busy,        x_busy);
            chk("reg_addr",    reg_addr,    x_addr[ADDR_W-1:0]);
            chk("data_out",    data_out,    x_dout);
            chk("reg_wdata",   reg_wdata,   x_wdata);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_sync = 1'b1;
        data_in   = b;
        model_byte(cyc, b);
        step(1);
        byte_sync = 1'b0;
        data_in   = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset(cyc);
        step(1);
        rst = 1'b0;
    endtask

    logic [7:0] mix [20];
    int         we0, err0, c0;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            stub_mem[i]  = 8'(i * 7 + 3);
            model_mem[i] = 8'(i * 7 + 3);
        end
        stub_mem[2]  = 8'hA7;
        model_mem[2] = 8'hA7;

        step(2);
        do_reset();
        cmp_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_addr", reg_addr, 0);
        chk("rst_strobes", {reg_we, reg_re, err_timeout}, 3'b000);
        step(4);

        // 1. write 0x3C to address 5
        we0 = we_cnt;
        send(8'h85); step(15);
        send(8'h3C);
        chk("wr_we", reg_we, 1);
        chk("wr_addr", reg_addr, 6'h05);
        chk("wr_wdata", reg_wdata, 8'h3C);
        chk("wr_busy", busy, 0);
        step(1);
        chk("wr_we_count", we_cnt - we0, 1);
        step(10);

        // 2. read address 2
        we0 = we_cnt;
        send(8'h02);
        chk("rd_re", reg_re, 1);
        step(1);
        chk("rd_dout", data_out, 8'hA7);
        step(14);
        send(8'hFF);
        chk("rd_dout_clr", data_out, 8'h00);
        chk("rd_no_we", we_cnt - we0, 0);
        step(10);

        // 3. timeout on a write, then a clean write
        we0 = we_cnt;
        send(8'h81);
        step(TMO - 1);
        chk("tmo_not_yet", err_timeout, 0);
        step(1);
        chk("tmo_err", err_timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_addr_kept", reg_addr, 6'h01);
        step(1);
        chk("tmo_no_we", we_cnt - we0, 0);
        step(10);
        send(8'h81); step(15);
        send(8'h11);
        chk("post_tmo_we", reg_we, 1);
        chk("post_tmo_wdata", reg_wdata, 8'h11);
        step(10);

        // 4. second byte lands on the terminal-count cycle
        err0 = err_cnt;
        send(8'h87);
        step(TMO - 1);
        send(8'h5A);
        chk("race_we", reg_we, 1);
        chk("race_wdata", reg_wdata, 8'h5A);
        step(TMO + 4);
        chk("race_no_err", err_cnt - err0, 0);

        // 5. reset while waiting for write data
        we0 = we_cnt;
        send(8'h85); step(5);
        do_reset();
        chk("rst_mid_busy", busy, 0);
        step(8);
        send(8'h3C);
        chk("rst_mid_re", reg_re, 1);
        chk("rst_mid_addr", reg_addr, 6'h3C);
        step(15);
        send(8'h00);
        chk("rst_mid_no_we", we_cnt - we0, 0);
        step(15);

        // 6. ten back-to-back mixed transactions at the minimum byte period
        mix = '{8'h81, 8'h11, 8'h01, 8'hFF, 8'h9F, 8'hC3, 8'h1F, 8'h00, 8'h82, 8'h55,
                8'h02, 8'hAA, 8'hBF, 8'h7E, 8'h3F, 8'h00, 8'h45, 8'h12, 8'hC5, 8'h99};
        c0 = re_cnt;
        for (int i = 0; i < 20; i++) begin
            send(mix[i]);
            step(15);
        end
        chk("mix_reads", re_cnt - c0, 5);
        chk("mix_mem5", stub_mem[5], 8'h99);
        chk("mix_mem31", stub_mem[31], 8'hC3);
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
